// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared state encoding and width defaults for pipeline_ctrl
package pipeline_ctrl_pkg;

  localparam int REG_AW_DEF = 6;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - two-slot EX/WB destination tracker with RAW hazard compare
module hazard_scoreboard
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_load_valid,
  input  logic [REG_AW-1:0] ex_load_rd,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  output logic              slots_empty,
  output logic              hazard
);

  logic              ex_valid_q, wb_valid_q;
  logic [REG_AW-1:0] ex_rd_q, wb_rd_q;
  logic              ex_hit, wb_hit;

  // Advance the slots every cycle: EX retires into WB, ID's destination enters EX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_rd_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
    end else begin
      wb_valid_q <= ex_valid_q;
      wb_rd_q    <= ex_rd_q;
      ex_valid_q <= ex_load_valid;
      ex_rd_q    <= ex_load_rd;
    end
  end

  // Register 0 is tracked like any other, so no zero-register exemption here
  always_comb begin
    ex_hit      = ex_valid_q && ((id_uses_rs && (ex_rd_q == id_rs)) ||
                                 (id_uses_rt && (ex_rd_q == id_rt)));
    wb_hit      = wb_valid_q && ((id_uses_rs && (wb_rd_q == id_rs)) ||
                                 (id_uses_rt && (wb_rd_q == id_rt)));
    hazard      = ex_hit || wb_hit;
    slots_empty = !ex_valid_q && !wb_valid_q;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - four-stage pipeline run/drain FSM, stall/flush decode and stall counter
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_reg_wrt,
  input  logic              id_halt,
  input  logic              ex_pc_change,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stall_cycles
);

  state_e           state_q;
  logic [CNT_W-1:0] stall_cycles_q;
  logic             hazard, slots_empty;
  logic             stall_hit, ex_load_valid;

  // Output decode: branch flush beats halt and hazard; DRAIN/IDLE/HALTED keep bubbles flowing
  always_comb begin
    pc_en         = 1'b0;
    ifid_en       = 1'b0;
    ifid_flush    = 1'b1;
    idex_flush    = 1'b1;
    stall_hit     = 1'b0;
    ex_load_valid = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (ex_pc_change) begin
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (hazard) begin
          ifid_flush = 1'b0;
          idex_flush = 1'b1;
          stall_hit  = 1'b1;
        end else begin
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          ifid_flush = 1'b0;
          idex_flush = 1'b0;
        end
        // A halt never writes a register, and a flushed slot carries nothing
        ex_load_valid = id_reg_wrt && !idex_flush && !id_halt;
      end
      ST_DRAIN: begin
        ifid_flush = 1'b0;
        idex_flush = 1'b1;
      end
      default: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
    endcase
  end

  hazard_scoreboard #(
    .REG_AW(REG_AW)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_load_valid(ex_load_valid),
    .ex_load_rd   (id_rd),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .slots_empty  (slots_empty),
    .hazard       (hazard)
  );

  // Control FSM plus saturating hazard-stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      stall_cycles_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HALTED: if (start) state_q <= ST_RUN;
        ST_RUN:             if (id_halt && !ex_pc_change) state_q <= ST_DRAIN;
        ST_DRAIN:           if (slots_empty) state_q <= ST_HALTED;
        default:            state_q <= ST_IDLE;
      endcase
      if (stall_hit && (stall_cycles_q != {CNT_W{1'b1}})) begin
        stall_cycles_q <= stall_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign state        = state_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed scoreboard bench for pipeline_ctrl
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [5:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rs, id_uses_rt, id_reg_wrt, id_halt, ex_pc_change;
  logic        pc_en, ifid_en, ifid_flush, idex_flush;
  logic [1:0]  state;
  logic [15:0] stall_cycles;
  logic        s_pc_en, s_ifid_en, s_ifid_flush, s_idex_flush;
  logic [1:0]  s_state;
  logic [2:0]  s_stall_cycles;

  typedef struct packed {
    logic [1:0]  st;
    logic [3:0]  outs;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [3:0] O_IDLE  = 4'b0011;
  localparam logic [3:0] O_RUN   = 4'b1100;
  localparam logic [3:0] O_STALL = 4'b0001;
  localparam logic [3:0] O_FLUSH = 4'b1111;
  localparam logic [3:0] O_DRAIN = 4'b0001;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_reg_wrt(id_reg_wrt), .id_halt(id_halt), .ex_pc_change(ex_pc_change),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .state(state), .stall_cycles(stall_cycles)
  );

  pipeline_ctrl #(.REG_AW(6), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_reg_wrt(id_reg_wrt), .id_halt(id_halt), .ex_pc_change(ex_pc_change),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
    .state(s_state), .stall_cycles(s_stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one ID-stage instruction, queue what this cycle must show, compare at the falling edge
  task automatic step(input string tag, input logic st,
                      input logic [5:0] rs, input logic [5:0] rt, input logic [5:0] rd,
                      input logic urs, input logic urt, input logic wrt,
                      input logic halt, input logic pcc,
                      input logic [1:0] es, input logic [3:0] eo, input logic [15:0] ec);
    exp_t e;
    start = st; id_rs = rs; id_rt = rt; id_rd = rd;
    id_uses_rs = urs; id_uses_rt = urt; id_reg_wrt = wrt;
    id_halt = halt; ex_pc_change = pcc;
    exp_q.push_back('{st: es, outs: eo, cnt: ec});
    @(negedge clk);
    e = exp_q.pop_front();
    chk(tag, {10'd0, state, pc_en, ifid_en, ifid_flush, idex_flush, stall_cycles},
             {10'd0, e.st, e.outs, e.cnt});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0;
    id_rs = '0; id_rt = '0; id_rd = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_reg_wrt = 1'b0;
    id_halt = 1'b0; ex_pc_change = 1'b0;
    #2;
    chk("reset_outs", {26'd0, state, pc_en, ifid_en, ifid_flush, idex_flush}, {26'd0, ST_IDLE, O_IDLE});
    chk("reset_cnt", {16'd0, stall_cycles}, 32'd0);
    chk("reset_sat_cnt", {29'd0, s_stall_cycles}, 32'd0);
    start = 1'b1;
    @(posedge clk); #1;
    chk("start_in_reset", {30'd0, state}, {30'd0, ST_IDLE});
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    //    tag          st rs    rt    rd    urs  urt  wrt  hlt  pcc  state      outs     cnt
    step("idle",      0, 6'd0, 6'd0, 6'd0, 0,   0,   0,   0,   0,   ST_IDLE,   O_IDLE,  16'd0);
    step("start",     1, 6'd0, 6'd0, 6'd0, 0,   0,   0,   0,   0,   ST_IDLE,   O_IDLE,  16'd0);
    step("run_nop",   0, 6'd0, 6'd0, 6'd0, 0,   0,   0,   0,   0,   ST_RUN,    O_RUN,   16'd0);
    step("add_r5",    0, 6'd1, 6'd2, 6'd5, 1,   1,   1,   0,   0,   ST_RUN,    O_RUN,   16'd0);
    step("d1_stall1", 0, 6'd5, 6'd0, 6'd0, 1,   0,   0,   0,   0,   ST_RUN,    O_STALL, 16'd0);
    step("d1_stall2", 0, 6'd5, 6'd0, 6'd0, 1,   0,   0,   0,   0,   ST_RUN,    O_STALL, 16'd1);
    step("d1_go",     0, 6'd5, 6'd0, 6'd0, 1,   0,   0,   0,   0,   ST_RUN,    O_RUN,   16'd2);
    step("add_r6",    0, 6'd0, 6'd0, 6'd6, 0,   0,   1,   0,   0,   ST_RUN,    O_RUN,   16'd2);
    step("indep_r9",  0, 6'd8, 6'd0, 6'd9, 1,   0,   1,   0,   0,   ST_RUN,    O_RUN,   16'd2);
    step("d2_stall",  0, 6'd0, 6'd6, 6'd0, 0,   1,   0,   0,   0,   ST_RUN,    O_STALL, 16'd2);
    step("d2_go",     0, 6'd0, 6'd6, 6'd0, 0,   1,   0,   0,   0,   ST_RUN,    O_RUN,   16'd3);
    step("add_r6b",   0, 6'd0, 6'd0, 6'd6, 0,   0,   1,   0,   0,   ST_RUN,    O_RUN,   16'd3);
    step("gap1",      0, 6'd0, 6'd0, 6'd0, 0,   0,   0,   0,   0,   ST_RUN,    O_RUN,   16'd3);
    step("gap2",      0, 6'd0, 6'd0, 6'd0, 0,   0,   0,   0,   0,   ST_RUN,    O_RUN,   16'd3);
    step("d3_go",     0, 6'd6, 6'd0, 6'd0, 1,   0,   0,   0,   0,   ST_RUN,    O_RUN,   16'd3);
    step("add_r0",    0, 6'd0, 6'd0, 6'd0, 0,   0,   1,   0,   0,   ST_RUN,    O_RUN,   16'd3);
    step("br_flush",  0, 6'd0, 6'd0, 6'd0, 1,   0,   0,   1,   1,   ST_RUN,    O_FLUSH, 16'd3);
    step("r0_stall",  0, 6'd0, 6'd0, 6'd0, 1,   0,   0,   0,   0,   ST_RUN,    O_STALL, 16'd3);
    step("post_r0",   0, 6'd0, 6'd0, 6'd0, 0,   0,   0,   0,   0,   ST_RUN,    O_RUN,   16'd4);
    step("add_r7",    0, 6'd0, 6'd0, 6'd7, 0,   0,   1,   0,   0,   ST_RUN,    O_RUN,   16'd4);
    step("halt",      0, 6'd0, 6'd0, 6'd0, 0,   0,   0,   1,   0,   ST_RUN,    O_RUN,   16'd4);
    step("drain1",    0, 6'd0, 6'd0, 6'd0, 0,   0,   0,   0,   1,   ST_DRAIN,  O_DRAIN, 16'd4);
    step("drain2",    0, 6'd0, 6'd0, 6'd0, 0,   0,   0,   0,   0,   ST_DRAIN,  O_DRAIN, 16'd4);
    step("halted",    1, 6'd0, 6'd0, 6'd0, 0,   0,   0,   0,   0,   ST_HALTED, O_IDLE,  16'd4);
    step("rerun",     0, 6'd0, 6'd0, 6'd0, 0,   0,   0,   0,   0,   ST_RUN,    O_RUN,   16'd4);
    step("add_r1",    0, 6'd0, 6'd0, 6'd1, 0,   0,   1,   0,   0,   ST_RUN,    O_RUN,   16'd4);
    step("r1_st1",    0, 6'd1, 6'd0, 6'd0, 1,   0,   0,   0,   0,   ST_RUN,    O_STALL, 16'd4);
    step("r1_st2",    0, 6'd1, 6'd0, 6'd0, 1,   0,   0,   0,   0,   ST_RUN,    O_STALL, 16'd5);
    step("add_r2",    0, 6'd1, 6'd0, 6'd2, 1,   0,   1,   0,   0,   ST_RUN,    O_RUN,   16'd6);
    step("r2_st1",    0, 6'd0, 6'd2, 6'd0, 0,   1,   0,   0,   0,   ST_RUN,    O_STALL, 16'd6);
    chk("sat_reach_max", {29'd0, s_stall_cycles}, 32'd7);
    step("r2_st2",    0, 6'd0, 6'd2, 6'd0, 0,   1,   0,   0,   0,   ST_RUN,    O_STALL, 16'd7);
    chk("sat_hold_max", {29'd0, s_stall_cycles}, 32'd7);
    step("add_r3",    0, 6'd2, 6'd0, 6'd3, 1,   0,   1,   0,   0,   ST_RUN,    O_RUN,   16'd8);
    step("r3_st1",    0, 6'd3, 6'd0, 6'd0, 1,   0,   0,   0,   0,   ST_RUN,    O_STALL, 16'd8);
    chk("main_cnt_9", {16'd0, stall_cycles}, 32'd9);
    chk("sat_no_wrap", {29'd0, s_stall_cycles}, 32'd7);

    // Mid-stall asynchronous reset: consumer of r3 still in ID and stalling
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", {26'd0, state, pc_en, ifid_en, ifid_flush, idex_flush}, {26'd0, ST_IDLE, O_IDLE});
    chk("midrst_cnt", {16'd0, stall_cycles}, 32'd0);
    chk("midrst_sat_cnt", {29'd0, s_stall_cycles}, 32'd0);
    start = 1'b1;
    @(posedge clk); #1;
    chk("midrst_start_ignored", {30'd0, state}, {30'd0, ST_IDLE});
    start = 1'b0;
    rst_n = 1'b1;
    step("rst_idle",  0, 6'd3, 6'd0, 6'd0, 1,   0,   0,   0,   0,   ST_IDLE,   O_IDLE,  16'd0);
    step("rst_start", 1, 6'd3, 6'd0, 6'd0, 1,   0,   0,   0,   0,   ST_IDLE,   O_IDLE,  16'd0);
    step("rst_use_r3",0, 6'd3, 6'd0, 6'd0, 1,   0,   0,   0,   0,   ST_RUN,    O_RUN,   16'd0);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 6, register-address width.
REQ-002 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  leave IDLE/HALTED.
REQ-006 SHALL have ports id_rs, id_rt, id_rd  input  REG_AW  register fields of the instruction in ID.
REQ-007 SHALL have ports id_uses_rs, id_uses_rt, id_reg_wrt, id_halt  input  1  decode qualifiers from control.
REQ-008 SHALL have port ex_pc_change  input  1  taken branch/jump resolved in EX.
REQ-009 SHALL have ports pc_en, ifid_en  output  1  PC load and IF/ID load enables.
REQ-010 SHALL have ports ifid_flush, idex_flush  output  1  force bubble into IF/ID and ID/EX.
REQ-011 SHALL have port state  output  2  IDLE=0, RUN=1, DRAIN=2, HALTED=3.
REQ-012 SHALL have port stall_cycles  output  CNT_W  hazard-stall count.

Function
REQ-013 SHALL model a four-stage pipeline: IF, ID, EX (incl. memory), WB; register file writes at the WB clock edge, reads are combinational.
REQ-014 SHALL keep a scoreboard of two slots, EX and WB, each {valid, rd}; every cycle WB <= EX, EX <= {ID writes register and not bubbled, id_rd}.
REQ-015 SHALL declare hazard when (id_uses_rs and valid slot rd == id_rs) or (id_uses_rt and valid slot rd == id_rt), either slot; all 64 registers are tracked, no zero-register exemption.
REQ-016 In RUN with hazard and no ex_pc_change: pc_en=0, ifid_en=0, ifid_flush=0, idex_flush=1, EX slot loads invalid; maximum stall 2 cycles.
REQ-017 In RUN with ex_pc_change: pc_en=1, ifid_flush=1, idex_flush=1, EX slot loads invalid; flush overrides hazard and id_halt (2-bubble branch penalty).
REQ-018 In RUN with neither: pc_en=1, ifid_en=1, both flushes 0.
REQ-019 RUN -> DRAIN when id_halt and no ex_pc_change; halt's EX slot entry is invalid.
REQ-020 DRAIN: pc_en=0, ifid_en=0, idex_flush=1; ex_pc_change ignored; -> HALTED on the cycle both slots are invalid.
REQ-021 IDLE and HALTED: pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1; start -> RUN next cycle; start ignored in RUN/DRAIN.
REQ-022 stall_cycles SHALL increment by 1 for each RUN cycle under REQ-016, saturate at all-ones, never wrap, clear only on reset.
REQ-023 All outputs except state and stall_cycles SHALL be combinational from state, scoreboard and inputs.

Reset
REQ-024 rst_n low SHALL immediately force state=IDLE, both slots invalid, stall_cycles=0, hence pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1.
REQ-025 Reset mid-RUN or mid-DRAIN SHALL discard all in-flight tracking; no start is accepted until rst_n has been high one edge.

Structure
REQ-026 Shared package pipeline_ctrl_pkg SHALL hold the state encoding, REG_AW and CNT_W defaults.
REQ-027 Scoreboard and hazard compare SHALL be sub-module hazard_scoreboard; FSM, output decode and counter live in pipeline_ctrl.

Verification
REQ-028 Reset, start=1 one cycle -> state 0 then 1; pc_en=1, flushes 0 next cycle.
REQ-029 add r5 (id_reg_wrt, id_rd=5) then consumer id_rs=5 -> exactly 2 cycles pc_en=0/idex_flush=1, stall_cycles=2.
REQ-030 Consumer at distance 2 (one independent instruction between) -> 1 stall cycle; distance 3 -> 0.
REQ-031 ex_pc_change=1 while ID holds hazard and id_halt -> pc_en=1, both flushes 1, state stays RUN, stall_cycles unchanged.
REQ-032 id_halt with r7 write in EX -> DRAIN for 2 cycles, then HALTED; start -> RUN.
REQ-033 Force stall_cycles to 0xFFFE via 3 hazards after preload -> holds at 0xFFFF; rst_n pulse mid-stall -> IDLE, counter 0.
